// File: rtl/des_pkg.sv
// Shared DES widths, sequencer state type and round-function tables.
package des_pkg;

  localparam int unsigned DES_BLOCK_W = 64;
  localparam int unsigned DES_KEY_W   = 48;
  localparam int unsigned DES_ROUNDS  = 16;
  localparam int unsigned DES_HALF_W  = DES_BLOCK_W / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } des_seq_state_t;

  typedef struct packed {
    logic [DES_HALF_W-1:0] l;
    logic [DES_HALF_W-1:0] r;
  } des_block_t;

  // S-boxes, 64 nibbles each, entry (row*16 + col) with entry 0 in the top nibble
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAEB17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // P permutation, 1-based source bit (1 = MSB) for each output bit MSB first
  localparam int unsigned P_TAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25
  };

  function automatic logic [3:0] des_sbox(input logic [255:0] tab, input logic [5:0] six);
    logic [5:0]   idx;
    logic [255:0] sh;
    idx = {six[5], six[0], six[4:1]};
    sh  = tab << {idx, 2'b00};
    return sh[255:252];
  endfunction

endpackage

// File: rtl/round.sv
// One DES Feistel round; the last round of a block omits the half swap.
module round
  import des_pkg::*;
(
  input  logic [DES_BLOCK_W-1:0] data_in,
  input  logic [DES_KEY_W-1:0]   key,
  input  logic                   last,
  output logic [DES_BLOCK_W-1:0] data_out
);

  des_block_t            blk;
  logic [DES_HALF_W-1:0] f_pre;
  logic [DES_HALF_W-1:0] f;
  logic [DES_HALF_W-1:0] new_r;

  assign blk = des_block_t'(data_in);

  // Expansion of R, key mix and S-box substitution, one 6-bit group per box
  for (genvar j = 0; j < 8; j++) begin : g_sbox
    logic [5:0] six;
    for (genvar b = 0; b < 6; b++) begin : g_e
      assign six[5-b] = blk.r[31-((4*j+b+31)%32)] ^ key[47-6*j-b];
    end
    assign f_pre[31-4*j -: 4] = des_sbox(SBOX_TAB[j], six);
  end

  for (genvar i = 0; i < 32; i++) begin : g_perm
    assign f[31-i] = f_pre[32-P_TAB[i]];
  end

  assign new_r    = blk.l ^ f;
  assign data_out = last ? {new_r, blk.r} : {blk.r, new_r};

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: one shared round instance stepped once per clock,
// with forward or reversed key ordering and valid/ready on both sides.
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = DES_ROUNDS,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DES_BLOCK_W-1:0] in_data,
  input  logic                   in_decrypt,
  input  logic                   abort,
  output logic [CNT_W-1:0]       key_idx,
  input  logic [DES_KEY_W-1:0]   key_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DES_BLOCK_W-1:0] out_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       round_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_ROUNDS - 1);

  des_seq_state_t         state_q, state_d;
  logic [DES_BLOCK_W-1:0] data_q, data_d;
  logic [DES_BLOCK_W-1:0] round_out;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dec_q, dec_d;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   last_round;

  assign last_round = (cnt_q == LAST_CNT);

  round u_round (
    .data_in  (data_q),
    .key      (key_in),
    .last     (last_round),
    .data_out (round_out)
  );

  // Next-state, datapath update and key index
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    key_idx = '0;
    case (state_q)
      IDLE: begin
        if (!abort && in_valid && in_ready_q) begin
          data_d  = in_data;
          dec_d   = in_decrypt;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        key_idx = dec_q ? (LAST_CNT - cnt_q) : cnt_q;
        if (abort) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          data_d = round_out;
          if (last_round) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (abort || out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags are registered off the next state so they track it exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      cnt_q       <= '0;
      dec_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      dec_q       <= dec_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;
  assign round_cnt = cnt_q;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: transaction-level model of the handshake/key order,
// a 16-stage reference chain for the data, and DES golden vectors.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_decrypt;
  logic        abort;
  logic [3:0]  key_idx;
  logic [47:0] key_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [3:0]  round_cnt;

  logic [47:0] key_store [16];
  logic [47:0] ks [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign key_in = key_store[key_idx];

  des_round_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_decrypt (in_decrypt),
    .abort      (abort),
    .key_idx    (key_idx),
    .key_in     (key_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .round_cnt  (round_cnt)
  );

  // Reference: unrolled chain of rounds with the keys captured at accept
  logic [63:0] ref_in;
  logic [47:0] ref_keys [16];
  logic [63:0] chain [17];
  assign chain[0] = ref_in;
  for (genvar g = 0; g < 16; g++) begin : g_ref
    round u_ref (
      .data_in  (chain[g]),
      .key      (ref_keys[g]),
      .last     (1'(g == 15)),
      .data_out (chain[g+1])
    );
  end

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[64-IP_T[i]] = x[63-i];
    return y;
  endfunction

  task automatic compute_ks(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2_T[i]];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 rounds in progress, 2 result held
  int          m_phase = 0;
  int          m_cnt   = 0;
  bit          m_dec   = 1'b0;
  bit          m_rdy   = 1'b0;
  int          kseq [$];

  task automatic tick();
    int exp_kidx;
    @(negedge clk);
    exp_kidx = (m_phase == 1) ? (m_dec ? 15 - m_cnt : m_cnt) : 0;
    chk("in_ready", 64'(in_ready), 64'(m_rdy));
    chk("busy", 64'(busy), 64'(m_phase != 0));
    chk("out_valid", 64'(out_valid), 64'(m_phase == 2));
    chk("round_cnt", 64'(round_cnt), 64'((m_phase == 1) ? m_cnt : 0));
    chk("key_idx", 64'(key_idx), 64'(exp_kidx));
    if (m_phase == 2) chk("out_data", out_data, chain[16]);
    if (m_phase == 1) kseq.push_back(int'(key_idx));
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_dec = 1'b0; m_rdy = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (!abort && in_valid && m_rdy) begin
            m_phase = 1; m_cnt = 0; m_rdy = 1'b0; m_dec = in_decrypt;
            ref_in = in_data;
            for (int i = 0; i < 16; i++) ref_keys[i] = key_store[in_decrypt ? 15 - i : i];
          end else begin
            m_rdy = 1'b1;
          end
        end
        1: begin
          if (abort) begin
            m_phase = 0; m_cnt = 0; m_rdy = 1'b1;
          end else if (m_cnt == 15) begin
            m_phase = 2; m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        default: begin
          if (abort || out_ready) begin
            m_phase = 0; m_rdy = 1'b1;
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [63:0] d, input bit dec, input bit keep);
    int n = 0;
    in_data = d; in_decrypt = dec; in_valid = 1'b1;
    while (!in_ready && n < 30) begin tick(); n++; end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    if (!keep) in_valid = 1'b0;
    kseq.delete();
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    if (!out_valid) chk("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic deliver();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [63:0] held, d;
    bit dec;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0;
    abort = 1'b0; out_ready = 1'b0; ref_in = '0;
    for (int i = 0; i < 16; i++) begin key_store[i] = '0; ref_keys[i] = '0; end
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_round_cnt", 64'(round_cnt), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Pin the key schedule and permutations against textbook values
    compute_ks(64'h133457799BBCDFF1);
    chk("ks_k1", 64'(ks[0]), 64'h1B02EFFC7072);
    chk("ks_k16", 64'(ks[15]), 64'hCB3D8B0E17F5);
    chk("ip_pt", ip(64'h0123456789ABCDEF), 64'hCC00CCFFF0AAF0AA);
    for (int i = 0; i < 16; i++) key_store[i] = ks[i];

    // Golden encrypt
    accept(64'hCC00CCFFF0AAF0AA, 1'b0, 1'b0);
    wait_out(lat);
    chk("enc_latency", 64'(lat), 64'd16);
    chk("enc_ct", fp(out_data), 64'h85E813540F0AB405);
    chk("enc_kseq_len", 64'(kseq.size()), 64'd16);
    for (int i = 0; i < kseq.size(); i++) chk("enc_kseq", 64'(kseq[i]), 64'(i));
    deliver();

    // Decrypt round trip
    accept(ip(64'h85E813540F0AB405), 1'b1, 1'b0);
    wait_out(lat);
    chk("dec_latency", 64'(lat), 64'd16);
    chk("dec_pt", fp(out_data), 64'h0123456789ABCDEF);
    chk("dec_kseq_len", 64'(kseq.size()), 64'd16);
    for (int i = 0; i < kseq.size(); i++) chk("dec_kseq", 64'(kseq[i]), 64'(15 - i));
    deliver();

    // Backpressure with the next block waiting upstream
    accept(64'hCC00CCFFF0AAF0AA, 1'b0, 1'b1);
    wait_out(lat);
    held = out_data;
    repeat (5) begin
      tick();
      chk("bp_stable", out_data, held);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    deliver();
    chk("bp_ready_after", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    kseq.delete();
    chk("bp_next_accepted", 64'(busy), 64'd1);
    wait_out(lat);
    chk("bp_next_ct", fp(out_data), 64'h85E813540F0AB405);
    deliver();

    // Abort mid-run, then a clean block
    accept(64'hCC00CCFFF0AAF0AA, 1'b0, 1'b0);
    n = 0;
    while (round_cnt != 4'd7 && n < 20) begin tick(); n++; end
    chk("abort_reach7", 64'(round_cnt), 64'd7);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_busy", 64'(busy), 64'd0);
    chk("abort_idle_ready", 64'(in_ready), 64'd1);
    repeat (18) tick();
    chk("abort_no_valid", 64'(out_valid), 64'd0);
    accept(64'hCC00CCFFF0AAF0AA, 1'b0, 1'b0);
    wait_out(lat);
    chk("abort_next_ct", fp(out_data), 64'h85E813540F0AB405);
    deliver();

    // Abort beats accept in idle
    in_valid = 1'b1; abort = 1'b1;
    tick();
    in_valid = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", 64'(busy), 64'd0);
    tick();

    // Asynchronous reset mid-run
    accept(64'hCC00CCFFF0AAF0AA, 1'b0, 1'b0);
    n = 0;
    while (round_cnt != 4'd10 && n < 20) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_round_cnt", 64'(round_cnt), 64'd0);
    m_phase = 0; m_cnt = 0; m_dec = 1'b0; m_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Random blocks and key stores against the reference chain
    for (int it = 0; it < 200; it++) begin
      for (int k = 0; k < 16; k++) key_store[k] = 48'({$urandom, $urandom});
      d   = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      accept(d, dec, 1'b0);
      wait_out(lat);
      chk("rnd_latency", 64'(lat), 64'd16);
      chk("rnd_equiv", out_data, chain[16]);
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 9) == 0) begin
        abort = 1'b1; out_ready = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0;
        chk("rnd_abort_ready_busy", 64'(busy), 64'd0);
      end else begin
        deliver();
      end
    end
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/des_round_sequencer.md
Name: des_round_sequencer

Overview:
- Iterative controller for the DES round datapath. It runs one shared single-round instance 16 times, one round per clock, in place of 16 unrolled stages.
- It sits between the initial permutation and the final permutation, with valid/ready handshakes on both sides.
- It fetches one 48-bit round key per cycle from the key-schedule store, via an index output.
- It orders keys forward for encrypt and reversed for decrypt, and supports abort.

Parameters:
- NUM_ROUNDS, 16, rounds per block; legal range 1..16, 16 for DES.
- CNT_W, 4, round-counter width; must be at least clog2(NUM_ROUNDS).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream block available.
- in_ready  output  1  sequencer can accept a block.
- in_data  input  64  block after initial permutation.
- in_decrypt  input  1  mode for this block, sampled at accept; 1 = reverse key order.
- abort  input  1  synchronous cancel of the current block.
- key_idx  output  CNT_W  index of the round key required this cycle.
- key_in  input  48  round key for key_idx, combinational, same cycle.
- out_valid  output  1  result held for downstream.
- out_ready  input  1  downstream accepts the result.
- out_data  output  64  block after NUM_ROUNDS rounds, to final permutation.
- busy  output  1  high in RUN or DONE.
- round_cnt  output  CNT_W  current round number, for debug.

Behaviour:
- States: IDLE, RUN, DONE. Reset enters IDLE; data_q=0, round_cnt=0, dec_q=0, out_valid=0, busy=0. in_ready=1 one cycle after reset deasserts.
- IDLE:
  - in_ready=1.
  - On in_valid and in_ready at edge E0: data_q<=in_data, dec_q<=in_decrypt, round_cnt<=0, go to RUN.
- RUN:
  - Each edge: data_q<=round(data_q, key_in), round_cnt<=round_cnt+1.
  - At round_cnt==NUM_ROUNDS-1: perform that round, go to DONE, round_cnt<=0.
- key_idx is combinational:
  - dec_q=0: key_idx=round_cnt.
  - dec_q=1: key_idx=NUM_ROUNDS-1-round_cnt.
  - In IDLE and DONE, key_idx=0.
- Timing: rounds are applied at edges E1..E16. out_valid=1 from E16 onward, so latency is 16 cycles from accept to result.
- DONE:
  - out_valid=1 and out_data=data_q, both stable until the handshake.
  - On out_ready, return to IDLE. in_ready rises the next cycle; no same-cycle accept, so the minimum block period is 18 cycles.
- out_data mirrors data_q at all times. It is only meaningful while out_valid=1.
- in_ready=0 in RUN and DONE. in_valid in those states is ignored and the upstream holds.
- abort:
  - In RUN or DONE: go to IDLE next edge, out_valid=0, round_cnt=0. data_q is not cleared.
  - In IDLE: no effect, and abort has priority over accept, so no block is accepted that cycle.
- abort and out_ready in the same DONE cycle: treated as abort; the result is not counted as delivered.
- rst_n low at any time, including mid-RUN: immediate return to reset values. The partial block is lost.
- Round semantics are identical to one stage of the unrolled chain, including last-round behaviour. The sequencer adds no swap.
- Round counter arithmetic is unsigned CNT_W and never wraps in RUN, because the exit happens at NUM_ROUNDS-1.

Decomposition:
- Shared package des_pkg holds:
  - DES_BLOCK_W=64, DES_KEY_W=48, DES_ROUNDS=16.
  - State enum type des_seq_state_t {IDLE, RUN, DONE}.
- One sub-module: the existing single-round datapath `round`, instantiated once and fed by data_q and key_in.
- The FSM, counter and key-index logic stay in des_round_sequencer.

Test Plan:
- Encrypt golden vector:
  - Stimulus: key store from key 133457799BBCDFF1; in_data=CC00CCFFF0AAF0AA (IP of 0123456789ABCDEF); in_decrypt=0.
  - Required: out_valid exactly 16 cycles after accept; final permutation of out_data = 85E813540F0AB405.
  - Required: key_idx sequence 0,1,...,15.
- Decrypt round trip:
  - Stimulus: IP of 85E813540F0AB405 with in_decrypt=1, same key store.
  - Required: final permutation of out_data = 0123456789ABCDEF; key_idx sequence 15,14,...,0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid, with in_valid held high.
  - Required: out_data stable and in_ready=0 throughout; one cycle after out_ready=1, in_ready=1 and the next block is accepted.
- Abort:
  - Stimulus: abort at round_cnt=7.
  - Required: IDLE next cycle, out_valid never asserts, and a new block then completes with the correct result.
- Reset mid-operation:
  - Stimulus: rst_n low at round_cnt=10.
  - Required: out_valid=0, busy=0 and round_cnt=0 immediately, without waiting for a clock edge.
- Equivalence:
  - Stimulus: 200 random in_data / key sets.
  - Required: out_data equals a 16-stage combinational chain of `round` for the same keys in the same order.
